// File: rtl/control_unit_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_fsm
//  Purpose  : Multicycle control unit for an RV32I subset (R, I-ALU, LOAD,
//             STORE, BRANCH). Sequences every instruction through
//             FETCH / DECODE / EXEC / MEM / WB and drives the datapath
//             control interface. It issues exactly one PC_load pulse per
//             retired instruction.
//  Ports    : clk, reset (async, active-high)
//             opcode[6:0], funct3[2:0], funct7_5 : instruction fields
//             mem_ready                           : data memory ready (MEM only)
//             WE_mem, WE_reg                      : memory / register-file writes
//             OP_MEM_I[1:0]                       : [0] ALU B = imm, [1] WB from mem
//             ADD_SUB                             : 0 add, 1 subtract
//             PC_load                             : PC register load enable
//             select_flags[2:0]                   : branch-flag mux select
//             illegal                             : sticky illegal-instruction flag
//             retired[CNT_W-1:0]                  : count of PC_load pulses
//             state[2:0]                          : current state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit_fsm #(
    parameter int FETCH_WAIT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             mem_ready,
    output logic             WE_mem,
    output logic             WE_reg,
    output logic [1:0]       OP_MEM_I,
    output logic             ADD_SUB,
    output logic             PC_load,
    output logic [2:0]       select_flags,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_ILLEGAL = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LD = 3'd2,
        CLS_ST = 3'd3,
        CLS_BR = 3'd4
    } class_t;

    localparam logic [6:0] c_op_r  = 7'b0110011;
    localparam logic [6:0] c_op_i  = 7'b0010011;
    localparam logic [6:0] c_op_ld = 7'b0000011;
    localparam logic [6:0] c_op_st = 7'b0100011;
    localparam logic [6:0] c_op_br = 7'b1100011;

    localparam int                c_wait_w    = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(FETCH_WAIT - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    class_t              r_class;
    logic [2:0]          r_funct3;
    logic                r_funct7_5;
    logic                r_we_reg;
    logic [1:0]          r_op_mem_i;
    logic                r_add_sub;
    logic                r_pc_load;
    logic [2:0]          r_select_flags;
    logic                r_st_in_mem;    // current state is MEM for a store
    logic                r_illegal;
    logic [CNT_W-1:0]    r_retired;

    // ------------------------------------------------------------------
    // Next-state / next-output wires
    // ------------------------------------------------------------------
    class_t              w_dec_class;
    logic                w_dec_valid;
    state_t              w_next_state;
    logic [c_wait_w-1:0] w_next_wait;
    class_t              w_next_class;
    logic [2:0]          w_next_funct3;
    logic                w_next_funct7_5;
    logic [1:0]          w_n_op_mem_i;
    logic                w_n_add_sub;
    logic                w_n_we_reg;
    logic                w_n_pc_load;
    logic [2:0]          w_n_select_flags;
    logic                w_n_st_in_mem;
    logic                w_st_commit;

    // ------------------------------------------------------------------
    // Opcode classification (only meaningful while in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_class = CLS_R;
        w_dec_valid = 1'b1;
        case (opcode)
            c_op_r:  w_dec_class = CLS_R;
            c_op_i:  w_dec_class = CLS_I;
            c_op_ld: w_dec_class = CLS_LD;
            c_op_st: w_dec_class = CLS_ST;
            c_op_br: begin
                w_dec_class = CLS_BR;
                // funct3 010/011 are not branch encodings
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    w_dec_valid = 1'b0;
                end
            end
            default: w_dec_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            S_FETCH: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_next_state = S_DECODE;
                    w_next_wait  = '0;
                end else begin
                    w_next_wait  = r_wait_cnt + c_wait_w'(1);
                end
            end
            S_DECODE: begin
                w_next_state = w_dec_valid ? S_EXEC : S_ILLEGAL;
            end
            S_EXEC: begin
                case (r_class)
                    CLS_LD, CLS_ST: w_next_state = S_MEM;
                    CLS_BR:         w_next_state = S_FETCH;
                    default:        w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next_state = (r_class == CLS_ST) ? S_FETCH : S_WB;
                end
            end
            S_WB:      w_next_state = S_FETCH;
            S_ILLEGAL: w_next_state = S_ILLEGAL;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Instruction fields are captured only on the DECODE->EXEC edge so the
    // outputs stay stable while the fetch path moves on.
    always_comb begin
        w_next_class    = r_class;
        w_next_funct3   = r_funct3;
        w_next_funct7_5 = r_funct7_5;
        if (r_state == S_DECODE && w_dec_valid) begin
            w_next_class    = w_dec_class;
            w_next_funct3   = funct3;
            w_next_funct7_5 = funct7_5;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs for the state being entered; registered below so they
    // line up with that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_n_op_mem_i     = 2'b00;
        w_n_add_sub      = 1'b0;
        w_n_we_reg       = 1'b0;
        w_n_pc_load      = 1'b0;
        w_n_select_flags = 3'd0;
        w_n_st_in_mem    = 1'b0;

        if (w_next_state == S_EXEC || w_next_state == S_MEM || w_next_state == S_WB) begin
            // Operand selects are established in EXEC and held through MEM/WB
            case (w_next_class)
                CLS_R: begin
                    w_n_op_mem_i = 2'b00;
                    w_n_add_sub  = w_next_funct7_5 & (w_next_funct3 == 3'b000);
                end
                CLS_I:   w_n_op_mem_i = 2'b01;
                CLS_LD:  w_n_op_mem_i = 2'b11;
                CLS_ST:  w_n_op_mem_i = 2'b01;
                CLS_BR:  w_n_add_sub  = 1'b1;
                default: w_n_op_mem_i = 2'b00;
            endcase
        end

        case (w_next_state)
            S_EXEC: begin
                if (w_next_class == CLS_BR) begin
                    w_n_pc_load = 1'b1;
                    case (w_next_funct3)
                        3'b000:  w_n_select_flags = 3'd1;
                        3'b001:  w_n_select_flags = 3'd2;
                        3'b100:  w_n_select_flags = 3'd3;
                        3'b101:  w_n_select_flags = 3'd4;
                        3'b110:  w_n_select_flags = 3'd5;
                        3'b111:  w_n_select_flags = 3'd6;
                        default: w_n_select_flags = 3'd0;
                    endcase
                end
            end
            S_MEM: begin
                w_n_st_in_mem = (w_next_class == CLS_ST);
            end
            S_WB: begin
                w_n_we_reg  = 1'b1;
                w_n_pc_load = 1'b1;
            end
            default: begin
                w_n_pc_load = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_FETCH;
            r_wait_cnt     <= '0;
            r_class        <= CLS_R;
            r_funct3       <= 3'b000;
            r_funct7_5     <= 1'b0;
            r_we_reg       <= 1'b0;
            r_op_mem_i     <= 2'b00;
            r_add_sub      <= 1'b0;
            r_pc_load      <= 1'b0;
            r_select_flags <= 3'd0;
            r_st_in_mem    <= 1'b0;
            r_illegal      <= 1'b0;
            r_retired      <= '0;
        end else begin
            r_state        <= w_next_state;
            r_wait_cnt     <= w_next_wait;
            r_class        <= w_next_class;
            r_funct3       <= w_next_funct3;
            r_funct7_5     <= w_next_funct7_5;
            r_we_reg       <= w_n_we_reg;
            r_op_mem_i     <= w_n_op_mem_i;
            r_add_sub      <= w_n_add_sub;
            r_pc_load      <= w_n_pc_load;
            r_select_flags <= w_n_select_flags;
            r_st_in_mem    <= w_n_st_in_mem;
            r_illegal      <= r_illegal | (w_next_state == S_ILLEGAL);
            if (PC_load) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive. The store commit must fall in the same MEM cycle in
    // which mem_ready is seen, so it is gated combinationally by mem_ready.
    // ------------------------------------------------------------------
    assign w_st_commit  = r_st_in_mem & mem_ready;

    assign WE_mem       = w_st_commit;
    assign WE_reg       = r_we_reg;
    assign OP_MEM_I     = r_op_mem_i;
    assign ADD_SUB      = r_add_sub;
    assign PC_load      = r_pc_load | w_st_commit;
    assign select_flags = r_select_flags;
    assign illegal      = r_illegal;
    assign retired      = r_retired;
    assign state        = r_state;

endmodule
`default_nettype wire
